// File: rtl/conv_window_sequencer.sv
// Gathers 3x3 windows from a single-port pixel RAM, drives the Laplacian unit and
// streams one signed result per window position into the output RAM.
module conv_window_sequencer #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int AW       = 16,
  parameter int CONV_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [71:0]   win_px,
  output logic          conv_en,
  input  logic [7:0]    conv_result,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic          wr_ready
);

  localparam int            LW         = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST   = LW'(CONV_LAT - 1);
  localparam logic [AW-1:0] C_LAST     = AW'(IMG_W - 3);
  localparam logic [AW-1:0] R_LAST     = AW'(IMG_H - 3);
  localparam logic [AW-1:0] PIX_STRIDE = AW'(IMG_W);
  localparam logic [AW-1:0] OUT_STRIDE = AW'(IMG_W - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_CONV,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t        state;
  logic [AW-1:0] r, c;
  logic [3:0]    k;
  logic [1:0]    kr, kc;
  logic [LW-1:0] lat_cnt;

  logic [AW-1:0] next_r, next_c;
  logic [1:0]    next_kr, next_kc;
  logic          last_col, last_row;

  function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] row, input logic [AW-1:0] col);
    return row * PIX_STRIDE + col;
  endfunction

  // NOTE: every output of this block is assigned in each path, so no latch can be inferred.
  always_comb begin
    last_col = (c == C_LAST);
    last_row = (r == R_LAST);
    next_c   = last_col ? '0 : c + 1'b1;
    next_r   = last_col ? r + 1'b1 : r;
    next_kc  = (kc == 2'd2) ? 2'd0 : kc + 2'd1;
    next_kr  = (kc == 2'd2) ? kr + 2'd1 : kr;
  end

  // NOTE: non-blocking assignments only, so every branch reads the pre-edge register values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      r       <= '0;
      c       <= '0;
      k       <= '0;
      kr      <= '0;
      kc      <= '0;
      lat_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      conv_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      win_px  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            busy    <= 1'b1;
            r       <= '0;
            c       <= '0;
            k       <= '0;
            kr      <= '0;
            kc      <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end

        // Pixels arrive one cycle after their read and shift in from the top,
        // so after nine shifts the first pixel read sits in the in1 slot.
        S_FETCH: begin
          if (k != 4'd0) win_px <= {rd_data, win_px[71:8]};
          if (k == 4'd8) begin
            state <= S_LAST;
            rd_en <= 1'b0;
          end else begin
            k       <= k + 4'd1;
            kr      <= next_kr;
            kc      <= next_kc;
            rd_addr <= pix_addr(r + AW'(next_kr), c + AW'(next_kc));
          end
        end

        S_LAST: begin
          win_px  <= {rd_data, win_px[71:8]};
          state   <= S_CONV;
          conv_en <= 1'b1;
          lat_cnt <= '0;
        end

        // The result is valid during the last enabled cycle and is captured
        // on the edge that leaves CONV, before the unit sees enable drop.
        S_CONV: begin
          if (lat_cnt == LAT_LAST) begin
            state   <= S_WRITE;
            conv_en <= 1'b0;
            wr_en   <= 1'b1;
            wr_data <= conv_result;
            wr_addr <= r * OUT_STRIDE + c;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_col && last_row) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              r       <= next_r;
              c       <= next_c;
              k       <= '0;
              kr      <= '0;
              kc      <= '0;
              rd_en   <= 1'b1;
              rd_addr <= pix_addr(next_r, next_c);
            end
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: a 4x4 instance and a 3x3 instance, each with a pixel RAM model
// and a 4-neighbour Laplacian unit model; expected writes are queued by the stimulus.
module tb_conv_window_sequencer;

  localparam int AW       = 16;
  localparam int CONV_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  // 4x4 instance
  logic          start, busy, done, rd_en, conv_en, wr_en, wr_ready;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    conv_result, wr_data;
  logic [71:0]   win_px;

  // 3x3 instance
  logic          start3, busy3, done3, rd_en3, conv_en3, wr_en3, wr_ready3;
  logic [AW-1:0] rd_addr3, wr_addr3;
  logic [7:0]    rd_data3 = 8'h00;
  logic [7:0]    conv_result3, wr_data3;
  logic [71:0]   win_px3;

  conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .AW(AW), .CONV_LAT(CONV_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win_px(win_px),
    .conv_en(conv_en), .conv_result(conv_result), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  conv_window_sequencer #(.IMG_W(3), .IMG_H(3), .AW(AW), .CONV_LAT(CONV_LAT)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3), .win_px(win_px3),
    .conv_en(conv_en3), .conv_result(conv_result3), .wr_en(wr_en3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_ready(wr_ready3)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel RAMs: one-cycle read latency.
  logic [7:0] img  [16];
  logic [7:0] img3 [16];
  always @(posedge clk) if (rd_en)  rd_data  <= img[rd_addr[3:0]];
  always @(posedge clk) if (rd_en3) rd_data3 <= img3[rd_addr3[3:0]];

  // Laplacian unit: 4*in5 - in2 - in4 - in6 - in8, valid during the last
  // enabled cycle of a CONV_LAT-long enable burst, zero otherwise.
  function automatic logic [7:0] lap(input logic [71:0] w);
    logic [9:0] s;
    s = {w[39:32], 2'b00} - w[15:8] - w[31:24] - w[47:40] - w[63:56];
    return s[7:0];
  endfunction

  int en_run = 0, en_run3 = 0;
  always @(posedge clk) begin
    en_run  <= (!rst_n || !conv_en)  ? 0 : en_run + 1;
    en_run3 <= (!rst_n || !conv_en3) ? 0 : en_run3 + 1;
  end
  assign conv_result  = (conv_en  && en_run  >= CONV_LAT - 1) ? lap(win_px)  : 8'h00;
  assign conv_result3 = (conv_en3 && en_run3 >= CONV_LAT - 1) ? lap(win_px3) : 8'h00;

  wr_t           exp_q[$];
  wr_t           exp3_q[$];
  logic [AW-1:0] rd3_q[$];

  int            acc_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int            done3_cnt = 0, done3_cyc = 0, start3_cyc = 0;
  int            viol = 0, conv_run = 0;
  bit            hold_pend = 0;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_data;

  // Output-RAM back-pressure: when enabled, stall the second write for 5 cycles.
  bit stall_en = 0;
  int stall_ctr = 0;
  initial wr_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (stall_en && wr_en && acc_cnt == 1 && stall_ctr < 5) begin
      wr_ready = 1'b0;
      stall_ctr++;
    end else begin
      wr_ready = 1'b1;
    end
  end

  // Monitor for the 4x4 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
      conv_run  = 0;
    end else begin
      if (hold_pend) begin
        check("hold_wr_en", wr_en, 1'b1);
        check("hold_wr_addr", wr_addr, hold_addr);
        check("hold_wr_data", wr_data, hold_data);
      end
      hold_pend = wr_en && !wr_ready;
      hold_addr = wr_addr;
      hold_data = wr_data;
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual addr=%0h data=%0h expected none", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("queue_empty_at_done", exp_q.size(), 0);
      end
      if (rd_en && wr_en) viol++;
      if (conv_en && (rd_en || wr_en)) viol++;
      if (conv_en) conv_run++;
      else if (conv_run != 0) begin
        check("conv_en_len", conv_run, CONV_LAT);
        conv_run = 0;
      end
    end
  end

  // Monitor for the 3x3 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en3) begin
        if (rd3_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read3: actual addr=%0h expected none", rd_addr3);
        end else begin
          check("rd_addr3", rd_addr3, rd3_q.pop_front());
        end
      end
      if (wr_en3 && wr_ready3) begin
        if (exp3_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write3: actual addr=%0h data=%0h expected none", wr_addr3, wr_data3);
        end else begin
          wr_t e;
          e = exp3_q.pop_front();
          check("wr_addr3", wr_addr3, e.addr);
          check("wr_data3", wr_data3, e.data);
        end
      end
      if (done3) begin
        done3_cnt++;
        done3_cyc = cyc;
        check("queue3_empty_at_done", exp3_q.size() + rd3_q.size(), 0);
      end
    end
  end

  task automatic push_wr(input logic [AW-1:0] addr, input logic [7:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  d0;
    bit  ok;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_conv_en"}, conv_en, 1'b0);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_rd_addr"}, rd_addr, '0);
    check({tag, "_wr_addr"}, wr_addr, '0);
    check({tag, "_wr_data"}, wr_data, '0);
    check({tag, "_win_px"}, win_px, '0);
  endtask

  task automatic load_flat(input logic [7:0] v);
    for (int i = 0; i < 16; i++) img[i] = v;
  endtask

  task automatic load_impulse();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[5] = 8'd50;
  endtask

  task automatic push_impulse_writes();
    push_wr(16'd0, 8'hC8);
    push_wr(16'd1, 8'hCE);
    push_wr(16'd2, 8'hCE);
    push_wr(16'd3, 8'h00);
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    check({name, "_busy_cleared"}, busy, 1'b0);
    check({name, "_done_pulse_1cyc"}, done, 1'b0);
  endtask

  initial begin
    start  = 1'b0;
    start3 = 1'b0;
    wr_ready3 = 1'b1;
    load_flat(8'h00);
    for (int i = 0; i < 16; i++) img3[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Flat image: Laplacian is zero everywhere.
    load_flat(8'd10);
    for (int i = 0; i < 4; i++) push_wr(AW'(i), 8'h00);
    acc_cnt = 0;
    pulse_start();
    check("flat_busy", busy, 1'b1);
    wait_done("flat_done", 200);
    check("flat_done_latency", done_cyc - start_cyc, 53);
    check_idle_after("flat");

    // Single bright pixel at (1,1): wrapped centre tap and negative neighbour taps.
    load_impulse();
    push_impulse_writes();
    acc_cnt = 0;
    pulse_start();
    wait_done("impulse_done", 200);
    check("impulse_done_latency", done_cyc - start_cyc, 53);
    check_idle_after("impulse");

    // Second write back-pressured for 5 cycles.
    push_impulse_writes();
    acc_cnt   = 0;
    stall_ctr = 0;
    stall_en  = 1;
    pulse_start();
    wait_done("stall_done", 200);
    check("stall_done_latency", done_cyc - start_cyc, 58);
    check("stall_cycles_applied", stall_ctr, 5);
    stall_en = 0;
    check_idle_after("stall");

    // Extra start pulses mid-frame are ignored.
    push_impulse_writes();
    acc_cnt = 0;
    pulse_start();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_done", 200);
    check("restart_done_latency", done_cyc - start_cyc, 53);
    repeat (3) @(negedge clk);
    check("restart_no_requeue", busy, 1'b0);

    // Reset during the CONV phase of window 2 aborts without done.
    push_wr(16'd0, 8'hC8);
    acc_cnt = 0;
    pulse_start();
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        #1;
        if (conv_en && acc_cnt == 1) begin
          hit = 1;
          break;
        end
      end
      if (!hit) begin
        checks++;
        errors++;
        $display("FAIL abort_reach_conv: window 2 CONV not reached within 200 cycles");
      end
    end
    begin
      int d0;
      d0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_zero("abort");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_done", done_cnt, d0);
      check("abort_stays_idle", busy, 1'b0);
    end

    // Clean frame after the abort.
    load_impulse();
    push_impulse_writes();
    acc_cnt = 0;
    pulse_start();
    wait_done("post_abort_done", 200);
    check("post_abort_done_latency", done_cyc - start_cyc, 53);

    // 3x3 image: one window, full read sweep 0..8, +40 result.
    for (int i = 0; i < 9; i++) img3[i] = 8'd10;
    img3[4] = 8'd20;
    for (int i = 0; i < 9; i++) rd3_q.push_back(AW'(i));
    begin
      wr_t e;
      e.addr = '0;
      e.data = 8'h28;
      exp3_q.push_back(e);
    end
    @(negedge clk);
    start3     = 1'b1;
    start3_cyc = cyc;
    @(negedge clk);
    start3 = 1'b0;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        #1;
        if (done3_cnt != 0) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL small_done: no done within 100 cycles");
      end
    end
    check("small_done_latency", done3_cyc - start3_cyc, 14);

    repeat (3) @(negedge clk);
    check("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
